caravel_user_bus_lite: RTL and testbench
========================================

// Module: caravel_user_bus_lite
// PURPOSE
//  Wishbone slave for the user-project side of the Caravel SoC. Serves the
//  user BRAM window at 0x3800_0000, where firmware copies and runs matmul(),
//  with a fixed multi-cycle read latency that models the SDRAM/BRAM path.
//  Also provides the 32-bit mprj output data register. Firmware writes
//  progress codes to bits [31:16] (checkbits) for the chip-level bench.
// PARAMETERS
//  RAM_AW      10            word-address width of user RAM (1024 x 32b = 4 KB)
//  READ_DELAY  10            cycles from request accept to read ack (>=1)
//  RAM_BASE    32'h3800_0000 user RAM window base (decode on adr[31:24])
//  GPIO_ADDR   32'h2600_000C mprj output data register address
// PORTS
//  clock      in   1   system clock, all logic on rising edge
//  resetb     in   1   asynchronous active-low reset
//  wbs_cyc_i  in   1   Wishbone cycle
//  wbs_stb_i  in   1   Wishbone strobe; request = cyc & stb
//  wbs_we_i   in   1   1 = write, 0 = read
//  wbs_sel_i  in   4   byte enables; bit n covers dat[8n+7:8n]
//  wbs_adr_i  in   32  byte address
//  wbs_dat_i  in   32  write data
//  wbs_ack_o  out  1   one-cycle acknowledge pulse
//  wbs_dat_o  out  32  read data, valid only while ack = 1, else 0
//  mprj_out   out  32  mprj output data register
//  checkbits  out  16  mprj_out[31:16]
// BEHAVIOUR
//  Reset (resetb = 0, async): FSM to IDLE, wbs_ack_o = 0, wbs_dat_o = 0,
//   mprj_out = 0, delay counter = 0. RAM contents are not cleared.
//  Decode: RAM hit when adr[31:24] = 8'h38. RAM word index = adr[RAM_AW+1:2];
//   higher bits alias, so the window wraps modulo 4 KB. GPIO hit when
//   adr = GPIO_ADDR exactly. All other addresses are unmapped.
//  FSM states and transitions:
//   IDLE: when a request is present, latch adr, we, sel and dat.
//    RAM read -> WAIT with count = READ_DELAY-1.
//    All other requests -> ACK.
//   WAIT: decrement count each cycle. At 0, read the RAM word -> ACK.
//    If stb or cyc drops, abort with no ack -> IDLE.
//   ACK: assert wbs_ack_o for exactly 1 cycle -> IDLE.
//  Latency from request accept: writes ack after 1 cycle, GPIO and unmapped
//   reads ack after 1 cycle, RAM reads ack after READ_DELAY cycles.
//   Back-to-back: a request still asserted in the IDLE cycle after ack starts
//   a new transaction.
//  Writes:
//   RAM write updates only the bytes enabled by sel.
//   GPIO write updates the enabled bytes of mprj_out. The new value is visible
//    on the cycle ack is asserted.
//   Unmapped writes are acked and ignored, so the bus never hangs.
//  Reads: RAM returns the stored word, GPIO returns mprj_out, unmapped
//   returns 32'h0. Read data ignores sel.
//  A write followed by a read of the same address returns the new data.
//  Reset mid-transaction aborts it: no ack, and a RAM write not yet acked
//   does not commit.
// TESTING
//  Reset with stb idle -> ack = 0, mprj_out = 0, checkbits = 16'h0000.
//  Write 32'hAB40_0000, sel 4'hF to 0x2600_000C -> ack 1 cycle later, checkbits
//   = 16'hAB40. Then write 003E, 0044, 004A, 0050, AB99 in bits [31:16]; each
//   appears on checkbits in order.
//  Write 32'hDEAD_BEEF to 0x3800_0010, then read it -> read ack exactly
//   READ_DELAY cycles after accept, data = 32'hDEAD_BEEF. A read of 0x3800_1010
//   (alias) returns the same word.
//  Write 32'h1122_3344 to 0x3800_0000 with sel 4'hF, then 32'hAABB_CCDD with
//   sel 4'b0101 -> read returns 32'h11BB_33DD.
//  Read 0x3000_0000 (unmapped) -> ack after 1 cycle, data 32'h0. A write there
//   leaves RAM and mprj_out unchanged.
//  Assert resetb = 0 midway through a RAM read wait -> no ack, FSM in IDLE,
//   mprj_out = 0. The next read after reset completes normally.

Source files
------------

// File: rtl/caravel_user_bus_lite.sv
`default_nettype none
// ============================================================================
// caravel_user_bus_lite : Wishbone slave with a user RAM window and the mprj
//                         output data register.
// Revision 1.0
// ============================================================================
module caravel_user_bus_lite #(
   parameter int          RAM_AW     = 10,
   parameter int          READ_DELAY = 10,
   parameter logic [31:0] RAM_BASE   = 32'h3800_0000,
   parameter logic [31:0] GPIO_ADDR  = 32'h2600_000C
) (
   input  logic        clock,
   input  logic        resetb,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic [31:0] mprj_out,
   output logic [15:0] checkbits
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_ACK  = 2'd2;
   localparam int         CW     = $clog2(READ_DELAY + 1);
   localparam int         DEPTH  = 1 << RAM_AW;

   logic [31:0]       mem_q [0:DEPTH-1];
   logic [1:0]        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [RAM_AW-1:0] idx_q, idx_d;
   logic              ack_q, ack_d;
   logic [31:0]       rdat_q, rdat_d;
   logic [31:0]       mprj_q, mprj_d;

   logic              w_req;
   logic              w_ram_hit;
   logic              w_gpio_hit;
   logic              w_accept;
   logic              w_ram_wr;
   logic [RAM_AW-1:0] w_idx;

   assign w_req      = wbs_cyc_i & wbs_stb_i;
   assign w_ram_hit  = (wbs_adr_i[31:24] == RAM_BASE[31:24]);
   assign w_gpio_hit = (wbs_adr_i == GPIO_ADDR);
   assign w_idx      = wbs_adr_i[RAM_AW+1:2];
   assign w_accept   = (state_q == S_IDLE) & w_req;
   // Writes commit on the accept edge so the ack cycle already shows them.
   assign w_ram_wr   = w_accept & w_ram_hit & wbs_we_i & resetb;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      ack_d   = 1'b0;
      rdat_d  = 32'h0;
      mprj_d  = mprj_q;
      case (state_q)
         S_IDLE: begin
            if (w_req) begin
               idx_d = w_idx;
               if (w_gpio_hit && wbs_we_i) begin
                  for (int b = 0; b < 4; b++) begin
                     if (wbs_sel_i[b]) mprj_d[8*b +: 8] = wbs_dat_i[8*b +: 8];
                  end
               end
               if (w_ram_hit && !wbs_we_i && (READ_DELAY > 1)) begin
                  state_d = S_WAIT;
                  cnt_d   = CW'(READ_DELAY - 1);
               end else begin
                  state_d = S_ACK;
                  ack_d   = 1'b1;
                  if (!wbs_we_i) begin
                     if (w_ram_hit)       rdat_d = mem_q[w_idx];
                     else if (w_gpio_hit) rdat_d = mprj_q;
                  end
               end
            end
         end
         S_WAIT: begin
            if (!w_req) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CW'(1)) begin
               state_d = S_ACK;
               cnt_d   = '0;
               ack_d   = 1'b1;
               rdat_d  = mem_q[idx_q];
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         ack_q   <= 1'b0;
         rdat_q  <= 32'h0;
         mprj_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         ack_q   <= ack_d;
         rdat_q  <= rdat_d;
         mprj_q  <= mprj_d;
      end
   end

   always_ff @(posedge clock) begin
      if (w_ram_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (wbs_sel_i[b]) mem_q[w_idx][8*b +: 8] <= wbs_dat_i[8*b +: 8];
         end
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = rdat_q;
   assign mprj_out  = mprj_q;
   assign checkbits = mprj_q[31:16];

endmodule
`default_nettype wire

// File: tb/tb_caravel_user_bus_lite.sv
`default_nettype none
// tb_caravel_user_bus_lite : vector table plus hand-written abort and reset
// sequences for the user bus slave.
module tb_caravel_user_bus_lite;

   localparam int RD     = 10;
   localparam int BUDGET = 50;

   logic        clock  = 1'b0;
   logic        resetb = 1'b0;
   logic        cyc    = 1'b0;
   logic        stb    = 1'b0;
   logic        we     = 1'b0;
   logic [3:0]  sel    = 4'h0;
   logic [31:0] adr    = 32'h0;
   logic [31:0] wdat   = 32'h0;
   logic        ack;
   logic [31:0] rdat;
   logic [31:0] mprj;
   logic [15:0] cb;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   caravel_user_bus_lite #(
      .RAM_AW    (10),
      .READ_DELAY(RD),
      .RAM_BASE  (32'h3800_0000),
      .GPIO_ADDR (32'h2600_000C)
   ) dut (
      .clock    (clock),
      .resetb   (resetb),
      .wbs_cyc_i(cyc),
      .wbs_stb_i(stb),
      .wbs_we_i (we),
      .wbs_sel_i(sel),
      .wbs_adr_i(adr),
      .wbs_dat_i(wdat),
      .wbs_ack_o(ack),
      .wbs_dat_o(rdat),
      .mprj_out (mprj),
      .checkbits(cb)
   );

   typedef struct {
      logic        w;
      logic [3:0]  s;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp_rd;
      int          exp_lat;
      logic [31:0] exp_mprj;
   } vec_t;

   vec_t v [17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One Wishbone transfer; lat = 0 means no ack within the budget.
   task automatic xfer(input logic w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output int lat,
                       output logic [31:0] mp, output logic ack_after);
      @(posedge clock); #1;
      cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
      lat = 0; rd = 32'h0; mp = 32'h0;
      for (int k = 1; k <= BUDGET; k++) begin
         @(posedge clock); #1;
         if (ack) begin
            lat = k; rd = rdat; mp = mprj;
            break;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clock); #1;
      ack_after = ack;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rd, mp;
      logic        aa;
      int          lat;
      int          acks;

      v[0]  = '{1'b1, 4'hF, 32'h2600_000C, 32'hAB40_0000, 32'h0,         1,  32'hAB40_0000};
      v[1]  = '{1'b1, 4'hF, 32'h2600_000C, 32'h003E_0000, 32'h0,         1,  32'h003E_0000};
      v[2]  = '{1'b1, 4'hF, 32'h2600_000C, 32'h0044_0000, 32'h0,         1,  32'h0044_0000};
      v[3]  = '{1'b1, 4'hF, 32'h2600_000C, 32'h004A_0000, 32'h0,         1,  32'h004A_0000};
      v[4]  = '{1'b1, 4'hF, 32'h2600_000C, 32'h0050_0000, 32'h0,         1,  32'h0050_0000};
      v[5]  = '{1'b1, 4'hF, 32'h2600_000C, 32'hAB99_0000, 32'h0,         1,  32'hAB99_0000};
      v[6]  = '{1'b1, 4'hF, 32'h3800_0010, 32'hDEAD_BEEF, 32'h0,         1,  32'hAB99_0000};
      v[7]  = '{1'b0, 4'hF, 32'h3800_0010, 32'h0,         32'hDEAD_BEEF, RD, 32'hAB99_0000};
      v[8]  = '{1'b0, 4'h0, 32'h3800_1010, 32'h0,         32'hDEAD_BEEF, RD, 32'hAB99_0000};
      v[9]  = '{1'b1, 4'hF, 32'h3800_0000, 32'h1122_3344, 32'h0,         1,  32'hAB99_0000};
      v[10] = '{1'b1, 4'h5, 32'h3800_0000, 32'hAABB_CCDD, 32'h0,         1,  32'hAB99_0000};
      v[11] = '{1'b0, 4'hF, 32'h3800_0000, 32'h0,         32'h11BB_33DD, RD, 32'hAB99_0000};
      v[12] = '{1'b0, 4'hF, 32'h3000_0000, 32'h0,         32'h0,         1,  32'hAB99_0000};
      v[13] = '{1'b1, 4'hF, 32'h3000_0000, 32'hFFFF_FFFF, 32'h0,         1,  32'hAB99_0000};
      v[14] = '{1'b0, 4'hF, 32'h3800_0000, 32'h0,         32'h11BB_33DD, RD, 32'hAB99_0000};
      v[15] = '{1'b0, 4'hF, 32'h2600_000C, 32'h0,         32'hAB99_0000, 1,  32'hAB99_0000};
      v[16] = '{1'b1, 4'h3, 32'h2600_000C, 32'h1234_5678, 32'h0,         1,  32'hAB99_5678};

      repeat (3) @(posedge clock);
      #1;
      check("reset_ack", {31'h0, ack}, 32'h0);
      check("reset_dat", rdat, 32'h0);
      check("reset_mprj", mprj, 32'h0);
      check("reset_checkbits", {16'h0, cb}, 32'h0);
      resetb = 1'b1;

      for (int i = 0; i < 17; i++) begin
         xfer(v[i].w, v[i].s, v[i].a, v[i].d, rd, lat, mp, aa);
         check($sformatf("v%0d_latency", i), lat, v[i].exp_lat);
         if (!v[i].w) check($sformatf("v%0d_rdata", i), rd, v[i].exp_rd);
         check($sformatf("v%0d_mprj_at_ack", i), mp, v[i].exp_mprj);
         check($sformatf("v%0d_checkbits", i), {16'h0, cb}, {16'h0, v[i].exp_mprj[31:16]});
         check($sformatf("v%0d_ack_single", i), {31'h0, aa}, 32'h0);
      end

      // Master abandons a RAM read mid-wait: no ack must ever appear.
      @(posedge clock); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3800_0010;
      repeat (4) @(posedge clock);
      #1;
      stb = 1'b0; cyc = 1'b0;
      acks = 0;
      for (int k = 0; k < 15; k++) begin
         @(posedge clock); #1;
         if (ack) acks++;
      end
      check("abort_no_ack", acks, 0);
      xfer(1'b0, 4'hF, 32'h3800_0010, 32'h0, rd, lat, mp, aa);
      check("after_abort_latency", lat, RD);
      check("after_abort_rdata", rd, 32'hDEAD_BEEF);

      // Reset lands in the middle of a RAM read wait.
      @(posedge clock); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3800_0010;
      repeat (5) @(posedge clock);
      #1;
      resetb = 1'b0;
      #1;
      check("midreset_ack", {31'h0, ack}, 32'h0);
      check("midreset_mprj", mprj, 32'h0);
      check("midreset_checkbits", {16'h0, cb}, 32'h0);
      acks = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clock); #1;
         if (ack) acks++;
      end
      check("midreset_no_ack", acks, 0);
      stb = 1'b0; cyc = 1'b0;
      @(posedge clock); #1;
      resetb = 1'b1;
      xfer(1'b0, 4'hF, 32'h3800_0010, 32'h0, rd, lat, mp, aa);
      check("after_reset_latency", lat, RD);
      check("after_reset_rdata", rd, 32'hDEAD_BEEF);
      check("after_reset_mprj", mp, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
